// File: rtl/alu_issue_sched.sv
// ============================================================================
// alu_issue_sched
// ----------------------------------------------------------------------------
// Reservation station that feeds a single ALU. Instructions arrive from
// dispatch with their operands either already known or tagged by the ROB
// index that will produce them. Each entry watches the ALU and load CDBs and
// captures its missing operands. Once both operands are present the entry is
// READY. One READY entry is issued per cycle into a bank of output registers.
//
// Build option:
//   ALU_SCHED_RR_EN - when defined, issue selection is round-robin. The search
//                     starts one above the last issued entry. When undefined,
//                     the lowest-index READY entry always wins.
//
// Ports:
//   clk_in, rst_in          clock (rising edge), async active-low reset
//   rdy_in                  global enable; all state holds while low
//   clr_in                  synchronous flush of every entry and the issue pulse
//   disp_*                  dispatched instruction (op, operands/tags, rob, PC, imm)
//   alu_cdb_*, lsb_cdb_*    result broadcasts used for operand capture
//   rs_full                 registered: every entry is occupied
//   rs_to_alu_*             registered issue port; rs_to_alu_ready pulses per issue
// ============================================================================
module alu_issue_sched #(
   parameter int RS_SIZE = 8,
   parameter int ROB_W   = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clr_in,

   input  logic             disp_valid,
   input  logic [5:0]       disp_op,
   input  logic [31:0]      disp_Vj,
   input  logic             disp_Qj_busy,
   input  logic [ROB_W-1:0] disp_Qj,
   input  logic [31:0]      disp_Vk,
   input  logic             disp_Qk_busy,
   input  logic [ROB_W-1:0] disp_Qk,
   input  logic [ROB_W-1:0] disp_rob_index,
   input  logic [31:0]      disp_PC,
   input  logic [31:0]      disp_imm,

   input  logic             alu_cdb_valid,
   input  logic [ROB_W-1:0] alu_cdb_rob_index,
   input  logic [31:0]      alu_cdb_value,

   input  logic             lsb_cdb_valid,
   input  logic [ROB_W-1:0] lsb_cdb_rob_index,
   input  logic [31:0]      lsb_cdb_value,

   output logic             rs_full,

   output logic             rs_to_alu_ready,
   output logic [5:0]       rs_to_alu_op,
   output logic [31:0]      rs_to_alu_rs1,
   output logic [31:0]      rs_to_alu_rs2,
   output logic [ROB_W-1:0] rs_to_alu_rob_index,
   output logic [31:0]      rs_to_alu_PC,
   output logic [31:0]      rs_to_alu_imm
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam int CNT_W = $clog2(RS_SIZE + 1);

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } entState_e;

   typedef struct packed {
      entState_e        st;
      logic [5:0]       op;
      logic [31:0]      vj;
      logic             qjBusy;
      logic [ROB_W-1:0] qj;
      logic [31:0]      vk;
      logic             qkBusy;
      logic [ROB_W-1:0] qk;
      logic [ROB_W-1:0] rob;
      logic [31:0]      pc;
      logic [31:0]      imm;
   } rsEntry_t;

   rsEntry_t         entries_q [RS_SIZE];
   rsEntry_t         entries_d [RS_SIZE];
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;

   logic             outReady_q, outReady_d;
   logic [5:0]       outOp_q, outOp_d;
   logic [31:0]      outRs1_q, outRs1_d;
   logic [31:0]      outRs2_q, outRs2_d;
   logic [ROB_W-1:0] outRob_q, outRob_d;
   logic [31:0]      outPc_q, outPc_d;
   logic [31:0]      outImm_q, outImm_d;

   logic             issueFound;
   logic [IDX_W-1:0] issueIdx;
   logic [IDX_W-1:0] candIdx;
   logic [IDX_W-1:0] searchStart;
   logic             freeFound;
   logic [IDX_W-1:0] freeIdx;
   logic             dispAccept;
   rsEntry_t         dispEntry;

`ifdef ALU_SCHED_RR_EN
   logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
   assign searchStart = rrPtr_q;
`else
   assign searchStart = '0;
`endif

   // Returns {busy, value}. A pending operand is filled from whichever CDB
   // carries its tag; checking the ALU bus first lets it win a double match.
   function automatic logic [32:0] captureOperand(
      input logic             busy,
      input logic [ROB_W-1:0] tag,
      input logic [31:0]      value,
      input logic             aluValid,
      input logic [ROB_W-1:0] aluTag,
      input logic [31:0]      aluValue,
      input logic             lsbValid,
      input logic [ROB_W-1:0] lsbTag,
      input logic [31:0]      lsbValue
   );
      logic [32:0] result;
      result = {busy, value};
      if (busy && aluValid && (aluTag == tag)) begin
         result = {1'b0, aluValue};
      end else if (busy && lsbValid && (lsbTag == tag)) begin
         result = {1'b0, lsbValue};
      end
      return result;
   endfunction

   // Build the entry that a dispatch would write, including same-cycle CDB
   // bypass so an operand broadcast alongside dispatch is not missed.
   always_comb begin
      dispEntry     = '0;
      dispEntry.op  = disp_op;
      dispEntry.qj  = disp_Qj;
      dispEntry.qk  = disp_Qk;
      dispEntry.rob = disp_rob_index;
      dispEntry.pc  = disp_PC;
      dispEntry.imm = disp_imm;
      {dispEntry.qjBusy, dispEntry.vj} = captureOperand(disp_Qj_busy, disp_Qj, disp_Vj,
         alu_cdb_valid, alu_cdb_rob_index, alu_cdb_value,
         lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_value);
      {dispEntry.qkBusy, dispEntry.vk} = captureOperand(disp_Qk_busy, disp_Qk, disp_Vk,
         alu_cdb_valid, alu_cdb_rob_index, alu_cdb_value,
         lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_value);
      dispEntry.st = (!dispEntry.qjBusy && !dispEntry.qkBusy) ? ST_READY : ST_WAIT;
   end

   // Issue pick and free-slot search. Only registered READY state is looked
   // at, so a CDB capture never reaches the issue port in the same cycle.
   always_comb begin
      issueFound = 1'b0;
      issueIdx   = '0;
      candIdx    = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         candIdx = searchStart + IDX_W'(i);
         if (!issueFound && (entries_q[candIdx].st == ST_READY)) begin
            issueFound = 1'b1;
            issueIdx   = candIdx;
         end
      end
      freeFound = 1'b0;
      freeIdx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (entries_q[i].st == ST_FREE) begin
            freeFound = 1'b1;
            freeIdx   = IDX_W'(i);
         end
      end
   end

   // Dispatch looks at the registered full flag, so a slot freed by an issue
   // this cycle only becomes available on the following cycle.
   assign dispAccept = disp_valid && !full_q && freeFound && rdy_in;

   // Next-state: flush wins over everything; otherwise capture, issue and
   // dispatch all happen together on distinct entries.
   always_comb begin
      entries_d  = entries_q;
      count_d    = count_q;
      full_d     = full_q;
      outReady_d = outReady_q;
      outOp_d    = outOp_q;
      outRs1_d   = outRs1_q;
      outRs2_d   = outRs2_q;
      outRob_d   = outRob_q;
      outPc_d    = outPc_q;
      outImm_d   = outImm_q;
`ifdef ALU_SCHED_RR_EN
      rrPtr_d    = rrPtr_q;
`endif
      if (clr_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i].st = ST_FREE;
         end
         count_d    = '0;
         full_d     = 1'b0;
         outReady_d = 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (entries_q[i].st == ST_WAIT) begin
               {entries_d[i].qjBusy, entries_d[i].vj} = captureOperand(
                  entries_q[i].qjBusy, entries_q[i].qj, entries_q[i].vj,
                  alu_cdb_valid, alu_cdb_rob_index, alu_cdb_value,
                  lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_value);
               {entries_d[i].qkBusy, entries_d[i].vk} = captureOperand(
                  entries_q[i].qkBusy, entries_q[i].qk, entries_q[i].vk,
                  alu_cdb_valid, alu_cdb_rob_index, alu_cdb_value,
                  lsb_cdb_valid, lsb_cdb_rob_index, lsb_cdb_value);
               if (!entries_d[i].qjBusy && !entries_d[i].qkBusy) begin
                  entries_d[i].st = ST_READY;
               end
            end
         end

         outReady_d = issueFound;
         if (issueFound) begin
            entries_d[issueIdx].st = ST_FREE;
            outOp_d  = entries_q[issueIdx].op;
            outRs1_d = entries_q[issueIdx].vj;
            outRs2_d = entries_q[issueIdx].vk;
            outRob_d = entries_q[issueIdx].rob;
            outPc_d  = entries_q[issueIdx].pc;
            outImm_d = entries_q[issueIdx].imm;
`ifdef ALU_SCHED_RR_EN
            rrPtr_d  = issueIdx + IDX_W'(1);
`endif
         end

         if (dispAccept) begin
            entries_d[freeIdx] = dispEntry;
         end

         count_d = count_q + CNT_W'(dispAccept) - CNT_W'(issueFound);
         full_d  = (count_d == CNT_W'(RS_SIZE));
      end
   end

   // State register; rdy_in low freezes every register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         count_q    <= '0;
         full_q     <= 1'b0;
         outReady_q <= 1'b0;
         outOp_q    <= '0;
         outRs1_q   <= '0;
         outRs2_q   <= '0;
         outRob_q   <= '0;
         outPc_q    <= '0;
         outImm_q   <= '0;
`ifdef ALU_SCHED_RR_EN
         rrPtr_q    <= '0;
`endif
      end else if (rdy_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries_q[i] <= entries_d[i];
         end
         count_q    <= count_d;
         full_q     <= full_d;
         outReady_q <= outReady_d;
         outOp_q    <= outOp_d;
         outRs1_q   <= outRs1_d;
         outRs2_q   <= outRs2_d;
         outRob_q   <= outRob_d;
         outPc_q    <= outPc_d;
         outImm_q   <= outImm_d;
`ifdef ALU_SCHED_RR_EN
         rrPtr_q    <= rrPtr_d;
`endif
      end
   end

   // Output mapping from the registered issue bank.
   always_comb begin
      rs_full             = full_q;
      rs_to_alu_ready     = outReady_q;
      rs_to_alu_op        = outOp_q;
      rs_to_alu_rs1       = outRs1_q;
      rs_to_alu_rs2       = outRs2_q;
      rs_to_alu_rob_index = outRob_q;
      rs_to_alu_PC        = outPc_q;
      rs_to_alu_imm       = outImm_q;
   end

endmodule

// File: tb/tb_alu_issue_sched.sv
// ============================================================================
// tb_alu_issue_sched
// ----------------------------------------------------------------------------
// Self-checking bench for alu_issue_sched. Expected issues are queued when the
// stimulus that makes them inevitable is driven and compared when the DUT
// pulses rs_to_alu_ready. Understands the ALU_SCHED_RR_EN build option.
// ============================================================================
module tb_alu_issue_sched;

   localparam int RS_SIZE = 8;
   localparam int ROB_W   = 4;
   localparam logic [5:0] OP_ADD  = 6'h33;
   localparam logic [5:0] OP_ADDI = 6'h13;

   logic             clk_in = 1'b0;
   logic             rst_in;
   logic             rdy_in;
   logic             clr_in;
   logic             disp_valid;
   logic [5:0]       disp_op;
   logic [31:0]      disp_Vj;
   logic             disp_Qj_busy;
   logic [ROB_W-1:0] disp_Qj;
   logic [31:0]      disp_Vk;
   logic             disp_Qk_busy;
   logic [ROB_W-1:0] disp_Qk;
   logic [ROB_W-1:0] disp_rob_index;
   logic [31:0]      disp_PC;
   logic [31:0]      disp_imm;
   logic             alu_cdb_valid;
   logic [ROB_W-1:0] alu_cdb_rob_index;
   logic [31:0]      alu_cdb_value;
   logic             lsb_cdb_valid;
   logic [ROB_W-1:0] lsb_cdb_rob_index;
   logic [31:0]      lsb_cdb_value;
   logic             rs_full;
   logic             rs_to_alu_ready;
   logic [5:0]       rs_to_alu_op;
   logic [31:0]      rs_to_alu_rs1;
   logic [31:0]      rs_to_alu_rs2;
   logic [ROB_W-1:0] rs_to_alu_rob_index;
   logic [31:0]      rs_to_alu_PC;
   logic [31:0]      rs_to_alu_imm;

   typedef struct {
      logic [ROB_W-1:0] rob;
      logic [31:0]      rs1;
      logic [31:0]      rs2;
      logic [31:0]      pc;
      logic [31:0]      imm;
      logic [5:0]       op;
   } expIssue_t;

   expIssue_t expQ[$];
   int checkCount = 0;
   int failCount  = 0;

   alu_issue_sched #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_Vj(disp_Vj),
      .disp_Qj_busy(disp_Qj_busy), .disp_Qj(disp_Qj), .disp_Vk(disp_Vk),
      .disp_Qk_busy(disp_Qk_busy), .disp_Qk(disp_Qk),
      .disp_rob_index(disp_rob_index), .disp_PC(disp_PC), .disp_imm(disp_imm),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_index(alu_cdb_rob_index),
      .alu_cdb_value(alu_cdb_value),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_index(lsb_cdb_rob_index),
      .lsb_cdb_value(lsb_cdb_value),
      .rs_full(rs_full),
      .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
      .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
      .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_PC(rs_to_alu_PC),
      .rs_to_alu_imm(rs_to_alu_imm)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(input logic [ROB_W-1:0] rob, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [5:0] op);
      expIssue_t e;
      e.rob = rob; e.rs1 = rs1; e.rs2 = rs2; e.pc = pc; e.imm = imm; e.op = op;
      expQ.push_back(e);
   endtask

   // Advance one edge, sample 1ns later and score any issue that occurred.
   task automatic tick();
      expIssue_t e;
      @(posedge clk_in);
      #1;
      if (rs_to_alu_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_issue", 64'(rs_to_alu_ready), 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("issue_rob", 64'(rs_to_alu_rob_index), 64'(e.rob));
            checkOutput("issue_rs1", 64'(rs_to_alu_rs1), 64'(e.rs1));
            checkOutput("issue_rs2", 64'(rs_to_alu_rs2), 64'(e.rs2));
            checkOutput("issue_pc",  64'(rs_to_alu_PC),  64'(e.pc));
            checkOutput("issue_imm", 64'(rs_to_alu_imm), 64'(e.imm));
            checkOutput("issue_op",  64'(rs_to_alu_op),  64'(e.op));
         end
      end
   endtask

   task automatic setAlu(input logic v, input logic [ROB_W-1:0] tag, input logic [31:0] val);
      alu_cdb_valid = v; alu_cdb_rob_index = tag; alu_cdb_value = val;
   endtask

   task automatic setLsb(input logic v, input logic [ROB_W-1:0] tag, input logic [31:0] val);
      lsb_cdb_valid = v; lsb_cdb_rob_index = tag; lsb_cdb_value = val;
   endtask

   task automatic driveDisp(input logic [5:0] op, input logic [31:0] vj, input logic qjb,
                            input logic [ROB_W-1:0] qj, input logic [31:0] vk,
                            input logic qkb, input logic [ROB_W-1:0] qk,
                            input logic [ROB_W-1:0] rob, input logic [31:0] pc,
                            input logic [31:0] imm);
      disp_valid = 1'b1; disp_op = op; disp_Vj = vj; disp_Qj_busy = qjb; disp_Qj = qj;
      disp_Vk = vk; disp_Qk_busy = qkb; disp_Qk = qk; disp_rob_index = rob;
      disp_PC = pc; disp_imm = imm;
   endtask

   // One dispatch cycle: present the instruction for exactly one edge.
   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] vj, input logic qjb,
                                input logic [ROB_W-1:0] qj, input logic [31:0] vk,
                                input logic qkb, input logic [ROB_W-1:0] qk,
                                input logic [ROB_W-1:0] rob, input logic [31:0] pc,
                                input logic [31:0] imm);
      driveDisp(op, vj, qjb, qj, vk, qkb, qk, rob, pc, imm);
      tick();
      disp_valid = 1'b0;
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; disp_valid = 1'b0;
      disp_op = '0; disp_Vj = '0; disp_Qj_busy = 1'b0; disp_Qj = '0;
      disp_Vk = '0; disp_Qk_busy = 1'b0; disp_Qk = '0; disp_rob_index = '0;
      disp_PC = '0; disp_imm = '0;
      setAlu(1'b0, '0, '0);
      setLsb(1'b0, '0, '0);

      // Reset state
      #12;
      checkOutput("rst_ready", 64'(rs_to_alu_ready), 64'd0);
      checkOutput("rst_full",  64'(rs_full), 64'd0);
      checkOutput("rst_rob",   64'(rs_to_alu_rob_index), 64'd0);
      checkOutput("rst_rs1",   64'(rs_to_alu_rs1), 64'd0);
      checkOutput("rst_imm",   64'(rs_to_alu_imm), 64'd0);
      rst_in = 1'b1;

      // ADDI with both operands known issues two edges after dispatch
      pushExp(4'd3, 32'd5, 32'd0, 32'h100, 32'd7, OP_ADDI);
      applyStimulus(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 32'h100, 32'd7);
      checkOutput("addi_edge1_ready", 64'(rs_to_alu_ready), 64'd0);
      tick();
      checkOutput("addi_edge2_ready", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("addi_drained", 64'(expQ.size()), 64'd0);

      // ADD blocked on tag 2, released by the ALU CDB
      pushExp(4'd4, 32'h10, 32'd3, 32'h104, 32'd0, OP_ADD);
      applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd2, 32'd3, 1'b0, 4'd0, 4'd4, 32'h104, 32'd0);
      tick();
      checkOutput("add_blocked", 64'(rs_to_alu_ready), 64'd0);
      setAlu(1'b1, 4'd2, 32'h10);
      tick();
      setAlu(1'b0, '0, '0);
      checkOutput("add_capture_edge", 64'(rs_to_alu_ready), 64'd0);
      tick();
      checkOutput("add_issue", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("add_drained", 64'(expQ.size()), 64'd0);

      // Same-cycle bypass from the load CDB at dispatch
      pushExp(4'd5, 32'd1, 32'h22, 32'h108, 32'd0, OP_ADD);
      setLsb(1'b1, 4'd6, 32'h22);
      applyStimulus(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd5, 32'h108, 32'd0);
      setLsb(1'b0, '0, '0);
      tick();
      checkOutput("bypass_issue", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("bypass_drained", 64'(expQ.size()), 64'd0);

      // Both CDBs carry the same tag: ALU value wins
      pushExp(4'd7, 32'hAA, 32'd4, 32'h10C, 32'd0, OP_ADD);
      applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd7, 32'd4, 1'b0, 4'd0, 4'd7, 32'h10C, 32'd0);
      setAlu(1'b1, 4'd7, 32'hAA);
      setLsb(1'b1, 4'd7, 32'hBB);
      tick();
      setAlu(1'b0, '0, '0);
      setLsb(1'b0, '0, '0);
      tick();
      checkOutput("aluwins_issue", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("aluwins_drained", 64'(expQ.size()), 64'd0);

      // Fill all entries, each blocked on its own tag
      for (int i = 0; i < RS_SIZE; i++) begin
         applyStimulus(OP_ADD, 32'd0, 1'b1, ROB_W'(i), 32'(100 + i), 1'b0, 4'd0,
                       ROB_W'(i), 32'(32'h200 + 4 * i), 32'd0);
         if (i == RS_SIZE - 2) checkOutput("full_at7", 64'(rs_full), 64'd0);
      end
      checkOutput("full_at8", 64'(rs_full), 64'd1);
      applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd9, 32'd200, 1'b0, 4'd0, 4'd9, 32'h300, 32'd0);
      checkOutput("full_drop9", 64'(rs_full), 64'd1);
      tick();
      checkOutput("full_no_issue", 64'(rs_to_alu_ready), 64'd0);

      // Release entry 1; it issues and the full flag drops at that edge
      pushExp(4'd1, 32'h1111, 32'd101, 32'h204, 32'd0, OP_ADD);
      setAlu(1'b1, 4'd1, 32'h1111);
      tick();
      setAlu(1'b0, '0, '0);
      checkOutput("full_at_capture", 64'(rs_full), 64'd1);
      tick();
      checkOutput("release_issue", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("full_after_issue", 64'(rs_full), 64'd0);

      // Ninth instruction is now accepted into the freed slot (entry 1)
      applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd9, 32'd200, 1'b0, 4'd0, 4'd9, 32'h300, 32'd0);
      checkOutput("full_refill", 64'(rs_full), 64'd1);

      // Entries 1 (rob 9) and 5 become ready together
`ifdef ALU_SCHED_RR_EN
      pushExp(4'd5, 32'h5555, 32'd105, 32'h214, 32'd0, OP_ADD);
      pushExp(4'd9, 32'h9999, 32'd200, 32'h300, 32'd0, OP_ADD);
`else
      pushExp(4'd9, 32'h9999, 32'd200, 32'h300, 32'd0, OP_ADD);
      pushExp(4'd5, 32'h5555, 32'd105, 32'h214, 32'd0, OP_ADD);
`endif
      setAlu(1'b1, 4'd9, 32'h9999);
      setLsb(1'b1, 4'd5, 32'h5555);
      tick();
      setAlu(1'b0, '0, '0);
      setLsb(1'b0, '0, '0);
      tick();
      checkOutput("order_first", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("order_pending", 64'(expQ.size()), 64'd1);
      tick();
      checkOutput("order_second", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("order_drained", 64'(expQ.size()), 64'd0);
      checkOutput("order_full", 64'(rs_full), 64'd0);

      // Flush with six entries waiting; a ready dispatch in the same cycle is lost
      driveDisp(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd12, 32'h700, 32'd0);
      clr_in = 1'b1;
      tick();
      clr_in = 1'b0;
      disp_valid = 1'b0;
      checkOutput("clr_full", 64'(rs_full), 64'd0);
      checkOutput("clr_ready", 64'(rs_to_alu_ready), 64'd0);
      setAlu(1'b1, 4'd0, 32'hDEAD);
      setLsb(1'b1, 4'd2, 32'hBEEF);
      tick();
      setAlu(1'b1, 4'd3, 32'h3);
      setLsb(1'b1, 4'd4, 32'h4);
      tick();
      setAlu(1'b0, '0, '0);
      setLsb(1'b0, '0, '0);
      tick();
      tick();
      checkOutput("clr_no_issue", 64'(rs_to_alu_ready), 64'd0);

      // Occupancy restarted from zero: seven fit without full, eighth fills
      for (int i = 0; i < RS_SIZE; i++) begin
         applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, ROB_W'(i), 32'h800, 32'd0);
         if (i == RS_SIZE - 2) checkOutput("clr_count_7", 64'(rs_full), 64'd0);
      end
      checkOutput("clr_count_8", 64'(rs_full), 64'd1);
      clr_in = 1'b1;
      tick();
      clr_in = 1'b0;
      checkOutput("clr2_full", 64'(rs_full), 64'd0);

      // rdy_in low freezes a ready entry and ignores dispatch
      pushExp(4'd10, 32'h77, 32'd0, 32'h400, 32'd0, OP_ADD);
      applyStimulus(OP_ADD, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd10, 32'h400, 32'd0);
      rdy_in = 1'b0;
      driveDisp(OP_ADD, 32'h99, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd13, 32'h404, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rdy_hold_ready", 64'(rs_to_alu_ready), 64'd0);
      end
      checkOutput("rdy_hold_full", 64'(rs_full), 64'd0);
      disp_valid = 1'b0;
      rdy_in = 1'b1;
      tick();
      checkOutput("rdy_resume", 64'(rs_to_alu_ready), 64'd1);
      checkOutput("rdy_drained", 64'(expQ.size()), 64'd0);
      tick();
      tick();
      checkOutput("rdy_no_extra", 64'(rs_to_alu_ready), 64'd0);

      // Asynchronous reset in the middle of an issue pulse
      pushExp(4'd11, 32'h33, 32'd0, 32'h500, 32'd0, OP_ADD);
      applyStimulus(OP_ADD, 32'h33, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd11, 32'h500, 32'd0);
      tick();
      checkOutput("pre_reset_issue", 64'(rs_to_alu_ready), 64'd1);
      #2;
      rst_in = 1'b0;
      #1;
      checkOutput("async_rst_ready", 64'(rs_to_alu_ready), 64'd0);
      checkOutput("async_rst_rob",   64'(rs_to_alu_rob_index), 64'd0);
      checkOutput("async_rst_rs1",   64'(rs_to_alu_rs1), 64'd0);
      checkOutput("async_rst_pc",    64'(rs_to_alu_PC), 64'd0);
      #2;
      rst_in = 1'b1;

      // First dispatch after reset is taken on the first edge
      pushExp(4'd12, 32'h44, 32'h55, 32'h600, 32'd9, OP_ADDI);
      applyStimulus(OP_ADDI, 32'h44, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 4'd12, 32'h600, 32'd9);
      checkOutput("post_rst_edge1", 64'(rs_to_alu_ready), 64'd0);
      tick();
      checkOutput("post_rst_issue", 64'(rs_to_alu_ready), 64'd1);
      tick();
      checkOutput("final_drained", 64'(expQ.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/alu_issue_sched.md
ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_W, default 4, ROB index width.
REQ-003 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rdy_in  input  1  global enable; when 0, all state holds.
REQ-006 SHALL have port clr_in  input  1  synchronous flush (mispredict).
REQ-007 SHALL have ports disp_valid 1 / disp_op 6 / disp_Vj 32 / disp_Qj_busy 1 / disp_Qj ROB_W / disp_Vk 32 / disp_Qk_busy 1 / disp_Qk ROB_W / disp_rob_index ROB_W / disp_PC 32 / disp_imm 32, all inputs, for the dispatched instruction.
REQ-008 SHALL have ports alu_cdb_valid 1 / alu_cdb_rob_index ROB_W / alu_cdb_value 32, inputs, for the ALU result broadcast.
REQ-009 SHALL have ports lsb_cdb_valid 1 / lsb_cdb_rob_index ROB_W / lsb_cdb_value 32, inputs, for the load-result broadcast.
REQ-010 SHALL have output rs_full 1, high when no free entry exists.
REQ-011 SHALL have outputs rs_to_alu_ready 1 / rs_to_alu_op 6 / rs_to_alu_rs1 32 / rs_to_alu_rs2 32 / rs_to_alu_rob_index ROB_W / rs_to_alu_PC 32 / rs_to_alu_imm 32, all registered.

Function
REQ-012 Each entry SHALL be in one of three states: FREE, WAIT (an operand is pending), or READY (both operands are captured).
REQ-013 Dispatch SHALL occur when disp_valid and !rs_full and rdy_in: the lowest-index FREE entry is written at the clock edge.
REQ-014 disp_valid while rs_full SHALL be ignored, with no state change.
REQ-015 Operand capture SHALL occur whenever a busy tag equals a valid CDB rob_index: the value is stored and busy cleared; this includes the dispatch cycle itself (same-cycle bypass).
REQ-016 When both CDBs match the same tag, the ALU CDB value SHALL win.
REQ-017 A READY entry SHALL become issue-eligible on the cycle after it reaches READY, so there is no combinational CDB-to-issue path.
REQ-018 Each cycle, at most one eligible entry SHALL be selected; it is copied to the rs_to_alu_* registers with rs_to_alu_ready=1 and returned to FREE at the same edge.
REQ-019 rs_to_alu_ready SHALL be a one-cycle pulse per issue; with no eligible entry it is 0 and the other rs_to_alu_* outputs hold their last values.
REQ-020 Default selection SHALL be the lowest-index eligible entry.
REQ-021 rs_full SHALL be registered and equal (occupied count == RS_SIZE) after the edge.
REQ-022 Simultaneous issue and dispatch while full SHALL be handled as follows: the dispatch is refused in that cycle, and the freed slot is usable on the next cycle.
REQ-023 The occupied count SHALL change by (+1 dispatch) + (-1 issue) per edge and never wrap.
REQ-024 clr_in SHALL take priority over dispatch, capture and issue: all entries go FREE, rs_to_alu_ready=0, and rs_full=0 on the next edge.

Reset
REQ-025 rst_in low SHALL immediately force all entries FREE, count=0, rs_full=0, rs_to_alu_ready=0, and all other rs_to_alu_* outputs 0, regardless of clock.
REQ-026 After rst_in deasserts, the first dispatch SHALL be accepted on the first rising edge with rdy_in=1.

Configuration
REQ-027 Macro ALU_SCHED_RR_EN: when defined, selection SHALL be round-robin, searching upward from (last issued index + 1) mod RS_SIZE, with the pointer reset to 0; when undefined, selection SHALL be fixed lowest-index per REQ-020 and no pointer is present.

Verification
REQ-028 Dispatch ADDI (rob 3), Vj=5, imm=7, no busy operands -> two edges later rs_to_alu_ready=1 with rs1=5, imm=7, rob_index=3.
REQ-029 Dispatch ADD with Qj busy on tag 2, then alu_cdb_valid with tag 2 and value 0x10 -> rs1=0x10 issued on the cycle after capture; a CDB in the same cycle as dispatch is also captured.
REQ-030 Fill all 8 entries with operands blocked -> rs_full=1 and a 9th dispatch is dropped; release one entry -> it issues, rs_full=0 one edge later, and the 9th dispatch is accepted afterward.
REQ-031 With entries 1 and 5 ready: without the macro, 1 issues then 5; with ALU_SCHED_RR_EN and last issued=3, 5 issues then 1.
REQ-032 Pulse clr_in with 4 entries occupied -> no further issue and rs_full=0; assert rst_in mid-issue -> rs_to_alu_ready drops to 0 asynchronously.
REQ-033 Hold rdy_in=0 with ready entries -> no issue and no state change until rdy_in returns to 1.
